// File: rtl/game_state_controller_pkg.sv
// game_state_controller_pkg: shared game constants, state encoding and score helper
package game_state_controller_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_DEAD = 2'd2
   } state_t;

   localparam logic signed [31:0] INVALID         = -32'sd1;
   localparam logic signed [31:0] PIPE_WIDTH      = 32'sd52;
   localparam logic signed [31:0] PIPE_GAP_HEIGHT = 32'sd100;
   localparam logic signed [31:0] SCREEN_WIDTH    = 32'sd640;

   // score plus 0..3 passed pipes, pinned at the 16-bit ceiling
   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {15'd0, b};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

endpackage

// File: rtl/game_state_controller_flap_edge_detect.sv
// flap_edge_detect: two-flop synchronizer for the raw button plus rising-edge pulse
module flap_edge_detect (
   input  logic iClock,
   input  logic iReset,
   input  logic iFlap,
   output logic oPulse
);

   logic sync0, sync1, prev;

   // synchronize the asynchronous button and remember the last synchronized level
   always_ff @(posedge iClock) begin
      if (iReset) begin
         sync0 <= 1'b0;
         sync1 <= 1'b0;
         prev  <= 1'b0;
      end else begin
         sync0 <= iFlap;
         sync1 <= sync0;
         prev  <= sync1;
      end
   end

   assign oPulse = sync1 & ~prev;

endmodule

// File: rtl/game_state_controller.sv
// game_state_controller: game FSM, round-robin collision check, scoring and high score
module game_state_controller
   import game_state_controller_pkg::*;
#(
   parameter int BIRD_X    = 160,
   parameter int BIRD_SIZE = 24,
   parameter int GROUND_Y  = 400,
   parameter int DEAD_HOLD = 25000000
) (
   input  logic               iClock,
   input  logic               iReset,
   input  logic               iFlap,
   input  logic signed [31:0] iBirdY,
   input  logic signed [31:0] iPipe1X,
   input  logic signed [31:0] iPipe1Y,
   input  logic signed [31:0] iPipe2X,
   input  logic signed [31:0] iPipe2Y,
   input  logic signed [31:0] iPipe3X,
   input  logic signed [31:0] iPipe3Y,
   output logic [1:0]         oState,
   output logic [15:0]        oScore,
   output logic [15:0]        oHighScore,
   output logic               oCollision
);

   localparam logic signed [31:0] BX   = 32'(BIRD_X);
   localparam logic signed [31:0] BS   = 32'(BIRD_SIZE);
   localparam logic signed [31:0] GY   = 32'(GROUND_Y);
   localparam logic [31:0]        HOLD = 32'(DEAD_HOLD);

   state_t             state, next_state;
   logic               flap, start, hit_q, pipe_hit, bounds;
   logic [1:0]         idx, score_inc;
   logic [2:0]         scores;
   logic [15:0]        score, high_score, score_next;
   logic [31:0]        dead_cnt;
   logic signed [31:0] sel_x, sel_y, bird_bot;
   logic signed [31:0] px [3];
   logic signed [31:0] py [3];
   logic signed [31:0] prev_x [3];

   flap_edge_detect u_flap (
      .iClock (iClock),
      .iReset (iReset),
      .iFlap  (iFlap),
      .oPulse (flap)
   );

   assign px    = '{iPipe1X, iPipe2X, iPipe3X};
   assign py    = '{iPipe1Y, iPipe2Y, iPipe3Y};
   assign start = state == ST_IDLE && flap;

   // collision check against the one pipe selected this cycle, plus the screen bounds
   always_comb begin
      sel_x    = idx == 2'd0 ? px[0] : idx == 2'd1 ? px[1] : px[2];
      sel_y    = idx == 2'd0 ? py[0] : idx == 2'd1 ? py[1] : py[2];
      bird_bot = iBirdY + BS;
      pipe_hit = sel_y != INVALID && sel_x < BX + BS && sel_x + PIPE_WIDTH > BX &&
                 (iBirdY < sel_y || bird_bot > sel_y + PIPE_GAP_HEIGHT);
      bounds   = iBirdY < 0 || bird_bot > GY;
   end

   // a pipe scores when its right edge crosses left of the bird's left edge this cycle
   always_comb begin
      scores = '0;
      for (int i = 0; i < 3; i++)
         scores[i] = state == ST_PLAY && py[i] != INVALID &&
                     prev_x[i] + PIPE_WIDTH >= BX && px[i] + PIPE_WIDTH < BX;
      score_inc  = 2'(scores[0]) + 2'(scores[1]) + 2'(scores[2]);
      score_next = sat_add16(score, score_inc);
   end

   // state register
   always_ff @(posedge iClock) begin
      if (iReset) state <= ST_IDLE;
      else        state <= next_state;
   end

   // next-state logic; the unused encoding falls back to IDLE
   always_comb begin
      next_state = ST_IDLE;
      case (state)
         ST_IDLE: next_state = flap ? ST_PLAY : ST_IDLE;
         ST_PLAY: next_state = hit_q ? ST_DEAD : ST_PLAY;
         ST_DEAD: next_state = flap && dead_cnt >= HOLD ? ST_IDLE : ST_DEAD;
         default: next_state = ST_IDLE;
      endcase
   end

   // outputs
   always_comb begin
      oState     = state;
      oScore     = score;
      oHighScore = high_score;
      oCollision = hit_q;
   end

   // datapath: pipe index, registered hit, score, high score, dead counter, previous X
   always_ff @(posedge iClock) begin
      if (iReset) begin
         idx        <= 2'd0;
         hit_q      <= 1'b0;
         score      <= 16'd0;
         high_score <= 16'd0;
         dead_cnt   <= 32'd0;
         for (int i = 0; i < 3; i++) prev_x[i] <= '0;
      end else begin
         idx        <= idx == 2'd2 ? 2'd0 : idx + 2'd1;
         hit_q      <= state == ST_PLAY && !hit_q && (pipe_hit || bounds);
         score      <= start ? 16'd0 : score_next;
         if (state == ST_PLAY && next_state == ST_DEAD && score_next > high_score)
            high_score <= score_next;
         dead_cnt   <= state != ST_DEAD ? 32'd0 : dead_cnt == HOLD ? dead_cnt : dead_cnt + 32'd1;
         for (int i = 0; i < 3; i++) prev_x[i] <= start ? '0 : px[i];
      end
   end

endmodule

// File: tb/tb_game_state_controller.sv
// tb_game_state_controller: directed checks of start timing, collisions, scoring, dead hold and reset
module tb_game_state_controller;

   logic               iClock = 1'b0;
   logic               iReset = 1'b1;
   logic               iFlap  = 1'b0;
   logic signed [31:0] iBirdY = 200;
   logic signed [31:0] p1x = 600, p1y = -1, p2x = 600, p2y = -1, p3x = 600, p3y = -1;
   logic [1:0]         oState;
   logic [15:0]        oScore, oHighScore;
   logic               oCollision;
   int                 n_cmp = 0;
   int                 n_bad = 0;
   logic               coll;

   game_state_controller #(.DEAD_HOLD(10)) dut (
      .iClock     (iClock),
      .iReset     (iReset),
      .iFlap      (iFlap),
      .iBirdY     (iBirdY),
      .iPipe1X    (p1x),
      .iPipe1Y    (p1y),
      .iPipe2X    (p2x),
      .iPipe2Y    (p2y),
      .iPipe3X    (p3x),
      .iPipe3Y    (p3y),
      .oState     (oState),
      .oScore     (oScore),
      .oHighScore (oHighScore),
      .oCollision (oCollision)
   );

   always #5 iClock = ~iClock;

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge iClock);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic do_flap;
      iFlap = 1'b1;
      cyc(3);
      iFlap = 1'b0;
      cyc(2);
   endtask

   // wait up to lim cycles for DEAD, noting any collision pulse on the way
   task automatic wait_dead(input string tag, input int lim, output logic seen);
      seen = 1'b0;
      for (int i = 0; i < lim; i++) begin
         cyc(1);
         if (oCollision) seen = 1'b1;
         if (oState == 2'd2) break;
      end
      check(tag, 32'(oState), 2);
   endtask

   // back to IDLE from DEAD once the hold has expired, then start a new run
   task automatic restart;
      iBirdY = 200;
      cyc(12);
      do_flap;
      check("restart_idle", 32'(oState), 0);
      do_flap;
      check("restart_play", 32'(oState), 1);
   endtask

   initial begin
      cyc(3);
      check("rst_state", 32'(oState), 0);
      check("rst_score", 32'(oScore), 0);
      check("rst_high", 32'(oHighScore), 0);
      check("rst_coll", 32'(oCollision), 0);
      iReset = 1'b0;
      iFlap  = 1'b1;
      cyc(2);
      check("start_early", 32'(oState), 0);
      cyc(1);
      check("start_edge3", 32'(oState), 1);
      iFlap = 1'b0;
      check("start_score", 32'(oScore), 0);
      p1x = 150; p1y = 200; iBirdY = 230;
      cyc(8);
      check("in_gap_state", 32'(oState), 1);
      check("in_gap_coll", 32'(oCollision), 0);
      p1y = -1;
      p2y = 200; p2x = 108;
      cyc(2);
      p2x = 107;
      cyc(1);
      check("score_p2", 32'(oScore), 1);
      cyc(3);
      check("score_once", 32'(oScore), 1);
      p2y = -1; p2x = 108;
      cyc(2);
      p2x = 107;
      cyc(2);
      check("score_invalid", 32'(oScore), 1);
      p1x = 108; p1y = 200; p3x = 108; p3y = 200;
      cyc(2);
      p1x = 107; p3x = 107;
      cyc(1);
      check("score_double", 32'(oScore), 3);
      p3y = -1;
      p1x = 150; iBirdY = 150;
      wait_dead("pipe_hit_dead", 4, coll);
      check("pipe_hit_coll", 32'(coll), 1);
      check("dead_score", 32'(oScore), 3);
      check("dead_high", 32'(oHighScore), 3);
      p1y = -1; iBirdY = 200;
      cyc(3);
      iFlap = 1'b1;
      cyc(3);
      check("early_flap", 32'(oState), 2);
      iFlap = 1'b0;
      cyc(4);
      iFlap = 1'b1;
      cyc(3);
      check("late_flap", 32'(oState), 0);
      check("idle_score", 32'(oScore), 3);
      check("idle_high", 32'(oHighScore), 3);
      iFlap = 1'b0;
      cyc(2);
      do_flap;
      check("run2_play", 32'(oState), 1);
      check("run2_clear", 32'(oScore), 0);
      p2x = 108; p2y = 200; p3x = 108; p3y = 200;
      cyc(2);
      p2x = 107; p3x = 107;
      cyc(1);
      check("run2_score", 32'(oScore), 2);
      iBirdY = 377;
      wait_dead("ground_dead", 2, coll);
      check("run2_high", 32'(oHighScore), 3);
      check("run2_score_hold", 32'(oScore), 2);
      p2y = -1; p3y = -1;
      restart;
      iBirdY = -1;
      wait_dead("ceiling_dead", 2, coll);
      restart;
      p2x = 108; p2y = 200;
      cyc(2);
      p2x = 107;
      cyc(1);
      check("run4_score", 32'(oScore), 1);
      iReset = 1'b1;
      cyc(1);
      check("midrst_state", 32'(oState), 0);
      check("midrst_score", 32'(oScore), 0);
      check("midrst_high", 32'(oHighScore), 0);
      check("midrst_coll", 32'(oCollision), 0);
      iReset = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
